// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } md_state_t;

   localparam int DIV_ITERS = 32;

   function automatic logic is_div_op(input md_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_mul_op(input md_op_t op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the muldiv sequencer.
interface muldiv_if;
   import muldiv_pkg::*;

   logic        req_valid;
   md_op_t      req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rd_hilo;
   logic        flush;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output req_valid, req_op, req_a, req_b, rd_hilo, flush,
      input  busy, stall, done, hi, lo
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rd_hilo, flush,
      output busy, stall, done, hi, lo
   );

endinterface

// File: rtl/muldiv_ctrl_divu_core.sv
// Unsigned restoring divider: one quotient bit per step, dividend shifts out of the quotient register.
module divu_core (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic        i_step,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic [31:0] o_quo_nxt,
   output logic [31:0] o_rem_nxt
);

   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_dvs;

   logic [32:0] w_rem_sh;
   logic [32:0] w_diff;
   logic        w_ge;

   // Partial remainder stays below the divisor, so bit 32 of the trial difference is the borrow.
   assign w_rem_sh  = {r_rem, r_quo[31]};
   assign w_diff    = w_rem_sh - {1'b0, r_dvs};
   assign w_ge      = ~w_diff[32];
   assign o_rem_nxt = w_ge ? w_diff[31:0] : w_rem_sh[31:0];
   assign o_quo_nxt = {r_quo[30:0], w_ge};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rem <= '0;
         r_quo <= '0;
         r_dvs <= '0;
      end else if (i_start) begin
         r_rem <= '0;
         r_quo <= i_dividend;
         r_dvs <= i_divisor;
      end else if (i_step) begin
         r_rem <= o_rem_nxt;
         r_quo <= o_quo_nxt;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning HI/LO.
// Optional MULDIV_DIV_EARLY_OUT_EN: trivial divides (zero divisor or |a| < |b|) finish one edge after acceptance.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int MUL_LAT = 3
) (
   input  logic    clk,
   input  logic    reset,
   muldiv_if.slave bus
);

   localparam int CNT_MAX = (MUL_LAT > DIV_ITERS) ? MUL_LAT : DIV_ITERS;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   md_state_t          r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;
   logic [31:0]        r_a_raw;
   logic               r_done;
   logic               r_q_neg;
   logic               r_r_neg;
   logic               r_dz;
   logic signed [63:0] r_prod_p [MUL_LAT];
`ifdef MULDIV_DIV_EARLY_OUT_EN
   logic               r_early;
`endif

   logic        w_accept;
   logic        w_signed;
   logic        w_div_start;
   logic        w_mul_start;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [31:0] w_quo_nxt;
   logic [31:0] w_rem_nxt;

   function automatic logic signed [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                                input logic sgn);
      logic signed [63:0] ea;
      logic signed [63:0] eb;
      ea = {{32{sgn & a[31]}}, a};
      eb = {{32{sgn & b[31]}}, b};
      return ea * eb;
   endfunction

   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [31:0] neg32(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   assign w_accept    = (r_state == IDLE) && bus.req_valid && !bus.flush;
   assign w_signed    = (bus.req_op == MD_MULT) || (bus.req_op == MD_DIV);
   assign w_div_start = w_accept && is_div_op(bus.req_op);
   assign w_mul_start = w_accept && is_mul_op(bus.req_op);
   assign w_mag_a     = mag32(bus.req_a, w_signed);
   assign w_mag_b     = mag32(bus.req_b, w_signed);

   divu_core u_divu (
      .clk        (clk),
      .reset      (reset),
      .i_start    (w_div_start),
      .i_step     (r_state == DIV),
      .i_dividend (w_mag_a),
      .i_divisor  (w_mag_b),
      .o_quo_nxt  (w_quo_nxt),
      .o_rem_nxt  (w_rem_nxt)
   );

   // Stage p0 captures the product at acceptance; later stages only delay it to MUL_LAT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MUL_LAT; i++) r_prod_p[i] <= '0;
      end else begin
         if (w_mul_start) r_prod_p[0] <= mul64(bus.req_a, bus.req_b, w_signed);
         for (int i = 1; i < MUL_LAT; i++) r_prod_p[i] <= r_prod_p[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_a_raw <= '0;
         r_done  <= 1'b0;
         r_q_neg <= 1'b0;
         r_r_neg <= 1'b0;
         r_dz    <= 1'b0;
`ifdef MULDIV_DIV_EARLY_OUT_EN
         r_early <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  case (bus.req_op)
                     MD_MULT, MD_MULTU: begin
                        r_cnt   <= CNT_W'(MUL_LAT - 1);
                        r_state <= MUL;
                     end
                     MD_DIV, MD_DIVU: begin
                        r_a_raw <= bus.req_a;
                        r_q_neg <= w_signed & (bus.req_a[31] ^ bus.req_b[31]);
                        r_r_neg <= w_signed & bus.req_a[31];
                        r_dz    <= (bus.req_b == 32'd0);
                        r_cnt   <= CNT_W'(DIV_ITERS - 1);
                        r_state <= DIV;
`ifdef MULDIV_DIV_EARLY_OUT_EN
                        r_early <= (bus.req_b == 32'd0) || (w_mag_a < w_mag_b);
`endif
                     end
                     MD_MTHI: r_hi <= bus.req_a;
                     MD_MTLO: r_lo <= bus.req_a;
                     default: ;
                  endcase
               end
            end
            MUL: begin
               if (bus.flush) begin
                  r_state <= IDLE;
               end else if (r_cnt == '0) begin
                  {r_hi, r_lo} <= r_prod_p[MUL_LAT-1];
                  r_done       <= 1'b1;
                  r_state      <= IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            DIV: begin
               if (bus.flush) begin
                  r_state <= IDLE;
`ifdef MULDIV_DIV_EARLY_OUT_EN
               end else if (r_early) begin
                  r_lo    <= r_dz ? 32'hFFFF_FFFF : 32'd0;
                  r_hi    <= r_a_raw;
                  r_done  <= 1'b1;
                  r_state <= IDLE;
`endif
               end else if (r_cnt == '0) begin
                  // Zero divisor bypasses sign fixup: quotient all ones, remainder is the raw dividend.
                  if (r_dz) begin
                     r_lo <= 32'hFFFF_FFFF;
                     r_hi <= r_a_raw;
                  end else begin
                     r_lo <= neg32(w_quo_nxt, r_q_neg);
                     r_hi <= neg32(w_rem_nxt, r_r_neg);
                  end
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy  = (r_state != IDLE);
   assign bus.stall = bus.busy & (bus.req_valid | bus.rd_hilo);
   assign bus.done  = r_done;
   assign bus.hi    = r_hi;
   assign bus.lo    = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: arithmetic reference model checked every cycle plus directed literal vectors.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = 32;
`ifdef MULDIV_DIV_EARLY_OUT_EN
   localparam bit EARLY_ON = 1'b1;
`else
   localparam bit EARLY_ON = 1'b0;
`endif
   localparam int EARLY_LAT = EARLY_ON ? 1 : DIV_LAT;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   muldiv_if bus();

   muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      longint sa;
      longint sb;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return sa * sb;
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   task automatic div_ref(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                          output logic [31:0] q, output logic [31:0] r);
      longint sa;
      longint sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   function automatic bit small_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      longint ma;
      longint mb;
      ma = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      mb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      return (b == 32'd0) || (ma < mb);
   endfunction

   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [31:0] m_hi   = '0;
   logic [31:0] m_lo   = '0;
   logic [31:0] m_rhi  = '0;
   logic [31:0] m_rlo  = '0;
   int          m_left = 0;

   always @(posedge clk or posedge reset) begin : model
      logic [63:0] p;
      logic [31:0] q;
      logic [31:0] r;
      bit          sgn;
      if (reset) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_left <= 0;
      end else begin
         m_done <= 1'b0;
         sgn = (bus.req_op == MD_MULT) || (bus.req_op == MD_DIV);
         if (!m_busy) begin
            if (bus.req_valid && !bus.flush) begin
               case (bus.req_op)
                  MD_MULT, MD_MULTU: begin
                     p = mul_ref(bus.req_a, bus.req_b, sgn);
                     m_rhi  <= p[63:32];
                     m_rlo  <= p[31:0];
                     m_left <= MUL_LAT;
                     m_busy <= 1'b1;
                  end
                  MD_DIV, MD_DIVU: begin
                     div_ref(bus.req_a, bus.req_b, sgn, q, r);
                     m_rlo  <= q;
                     m_rhi  <= r;
                     m_left <= (EARLY_ON && small_div(bus.req_a, bus.req_b, sgn)) ? 1 : DIV_LAT;
                     m_busy <= 1'b1;
                  end
                  MD_MTHI: m_hi <= bus.req_a;
                  MD_MTLO: m_lo <= bus.req_a;
                  default: ;
               endcase
            end
         end else if (bus.flush) begin
            m_busy <= 1'b0;
         end else if (m_left == 1) begin
            m_hi   <= m_rhi;
            m_lo   <= m_rlo;
            m_done <= 1'b1;
            m_busy <= 1'b0;
         end else begin
            m_left <= m_left - 1;
         end
      end
   end

   always @(negedge clk) begin
      chk("mdl_busy",  32'(bus.busy),  32'(m_busy));
      chk("mdl_done",  32'(bus.done),  32'(m_done));
      chk("mdl_stall", 32'(bus.stall), 32'(m_busy & (bus.req_valid | bus.rd_hilo)));
      chk("mdl_hi",    bus.hi, m_hi);
      chk("mdl_lo",    bus.lo, m_lo);
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_done(input int limit, output int k);
      k = 0;
      while (!bus.done && k < limit) begin
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic run_op(input string nm, input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int elat);
      int k;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      wait_done(100, k);
      chk({nm, "_lat"}, 32'(k), 32'(elat));
      chk({nm, "_hi"}, bus.hi, ehi);
      chk({nm, "_lo"}, bus.lo, elo);
   endtask

   initial begin
      int k;
      int cnt;
      bus.req_valid = 1'b0;
      bus.req_op    = MD_MULT;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rd_hilo   = 1'b0;
      bus.flush     = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      chk("rst_hi",   bus.hi, 32'd0);
      chk("rst_lo",   bus.lo, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);

      // MTHI while IDLE with a concurrent HI/LO read: no stall, HI updates next cycle
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = MD_MTHI;
      bus.req_a     = 32'h0000_1234;
      bus.rd_hilo   = 1'b1;
      #1;
      chk("mthi_stall", 32'(bus.stall), 32'd0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.rd_hilo   = 1'b0;
      chk("mthi_hi",   bus.hi, 32'h0000_1234);
      chk("mthi_busy", 32'(bus.busy), 32'd0);
      chk("mthi_done", 32'(bus.done), 32'd0);

      // flush in IDLE drops MTLO
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = MD_MTLO;
      bus.req_a     = 32'hDEAD_BEEF;
      bus.flush     = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      chk("mtlo_flush_lo", bus.lo, 32'd0);

      run_op("mult",   MD_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT);
      run_op("multu",  MD_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MUL_LAT);
      run_op("div_n7", MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
      run_op("div_7n", MD_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_LAT);
      run_op("divu",   MD_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
      run_op("div_ov", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT);
      run_op("divu_z", MD_DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, EARLY_LAT);
      run_op("divu_s", MD_DIVU,  32'd3, 32'd9, 32'd3, 32'd0, EARLY_LAT);
      run_op("div_z",  MD_DIV,   32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, EARLY_LAT);

      // HI/LO read held across a divide: stalls every busy cycle, released in the done cycle
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = MD_DIVU;
      bus.req_a     = 32'd1000;
      bus.req_b     = 32'd33;
      bus.rd_hilo   = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      k   = 0;
      cnt = 0;
      while (!bus.done && k < 100) begin
         if (bus.stall) cnt++;
         @(posedge clk);
         #1;
         k++;
      end
      chk("rd_stall_cycles", 32'(cnt), 32'd32);
      chk("rd_stall_done",   32'(bus.stall), 32'd0);
      chk("rd_lat",          32'(k), 32'd32);
      chk("rd_hi",           bus.hi, 32'd10);
      chk("rd_lo",           bus.lo, 32'd30);
      bus.rd_hilo = 1'b0;

      // flush in the 10th DIV cycle
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = MD_DIV;
      bus.req_a     = 32'd100;
      bus.req_b     = 32'd7;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("flush_busy_pre", 32'(bus.busy), 32'd1);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      chk("flush_busy", 32'(bus.busy), 32'd0);
      cnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) cnt++;
      end
      chk("flush_no_done", 32'(cnt), 32'd0);
      chk("flush_hi", bus.hi, 32'd10);
      chk("flush_lo", bus.lo, 32'd30);

      // asynchronous reset in the middle of a multiply
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = MD_MULTU;
      bus.req_a     = 32'd7;
      bus.req_b     = 32'd6;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("rstmid_hi",   bus.hi, 32'd0);
      chk("rstmid_lo",   bus.lo, 32'd0);
      chk("rstmid_busy", 32'(bus.busy), 32'd0);
      #4;
      reset = 1'b0;
      cnt = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (bus.done) cnt++;
      end
      chk("rstmid_no_done", 32'(cnt), 32'd0);
      chk("rstmid_lo_after", bus.lo, 32'd0);

      // back-to-back: DIVU held under stall, accepted in the MULTU done cycle
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = MD_MULTU;
      bus.req_a     = 32'd7;
      bus.req_b     = 32'd6;
      @(posedge clk);
      #1;
      bus.req_op = MD_DIVU;
      bus.req_a  = 32'd1001;
      bus.req_b  = 32'd10;
      chk("b2b_stall", 32'(bus.stall), 32'd1);
      wait_done(100, k);
      chk("b2b_mul_lat",   32'(k), 32'(MUL_LAT));
      chk("b2b_mul_hi",    bus.hi, 32'd0);
      chk("b2b_mul_lo",    bus.lo, 32'd42);
      chk("b2b_done_stall", 32'(bus.stall), 32'd0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("b2b_accepted", 32'(bus.busy), 32'd1);
      wait_done(100, k);
      chk("b2b_div_lat", 32'(k), 32'd32);
      chk("b2b_div_hi",  bus.hi, 32'd1);
      chk("b2b_div_lo",  bus.lo, 32'd100);

      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer beside the execute-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests decoded in E and owns the HI/LO registers.
- Iterates a shared multiply/divide datapath.
- Raises a stall to the pipeline control when a new muldiv op or an HI/LO read hits while it is busy.

Parameters:
- MUL_LAT, 3: cycles from multiply acceptance to HI/LO write; legal range is 1 or more.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  muldiv op present in E this cycle.
- req_op  in  3  md_op_t: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
- req_a  in  32  rs value (dividend/multiplicand; MTHI/MTLO source).
- req_b  in  32  rt value (divisor/multiplier).
- rd_hilo  in  1  MFHI/MFLO present in E this cycle.
- flush  in  1  abort in-flight op, drop any request this cycle.
- busy  out  1  state != IDLE.
- stall  out  1  busy & (req_valid | rd_hilo); combinational.
- done  out  1  one-cycle pulse, high in the first cycle new HI/LO are visible.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, immediate): state=IDLE; hi=lo=0; busy=0; done=0; iteration counter and operand latches cleared. Reset mid-operation discards the op.
- States: IDLE, MUL, DIV.
- Accept rule: a request is accepted only in IDLE with req_valid & ~flush, on edge N. While busy, requests are ignored; upstream holds them under stall.
- IDLE, MULT/MULTU: latch operands, cnt=MUL_LAT-1, go to MUL.
- IDLE, DIV/DIVU: latch |a|, |b| (raw values for DIVU) and sign bits, cnt=31, go to DIV.
- IDLE, MTHI/MTLO: write hi or lo with req_a at edge N; stay IDLE; no stall; no done.
- MUL: cnt decrements each edge.
  - At cnt==0: {hi,lo} = 64-bit product (signed for MULT, unsigned for MULTU), then go to IDLE.
  - HI/LO first valid after edge N+MUL_LAT; done high that cycle.
- DIV: restoring radix-2, one quotient bit per edge, 32 iterations.
  - The final iteration also applies sign fixup: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Result lo=quotient, hi=remainder, written at edge N+32; then IDLE with done high.
- Divide by zero (both signed and unsigned): lo=0xFFFFFFFF, hi=req_a raw.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- flush:
  - In MUL/DIV: go to IDLE next edge; hi/lo unchanged; no done.
  - In IDLE: flush has priority over accept; the request is dropped, including MTHI/MTLO.
- Completion cycle is IDLE, so stall=0 and a new request may be accepted on that cycle's edge (back-to-back ops).
- rd_hilo while IDLE: no stall; the reader sees the current hi/lo.

Optional Feature:
- Macro: MULDIV_DIV_EARLY_OUT_EN.
- Defined: in DIV, if the divisor is zero or |dividend| < |divisor|, the result is written at edge N+1, with done in the following cycle.
  - Results: lo=0, hi=dividend (signed fixup applied); divide-by-zero values as above.
- Undefined: every divide takes 32 iterations.

Decomposition:
- Package muldiv_pkg holds:
  - typedef md_op_t (3-bit enum above);
  - typedef md_state_t (IDLE, MUL, DIV);
  - constant DIV_ITERS=32.
- One sub-module, divu_core: unsigned restoring-divide iteration registers (remainder, quotient, shift), driven by start/step from the controller.
- Sign handling and sequencing stay in muldiv_ctrl.
- The multiplier is a registered product shifted through a MUL_LAT-deep delay.

Test Plan:
- MULT 0xFFFFFFFE×3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA, done at edge N+3; MULTU same operands → hi=0x2, lo=0xFFFFFFFA.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF at edge N+32; DIVU 100/7 → lo=14, hi=2; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5/0 → lo=0xFFFFFFFF, hi=5 at edge N+32; with the macro defined, at edge N+1. DIVU 3/9 with the macro → lo=0, hi=3 at N+1.
- rd_hilo held during DIV → stall=1 every cycle until the done cycle, then 0; MTHI 0x1234 while IDLE → hi=0x1234 next cycle, stall never asserted.
- flush at cycle 10 of DIV → busy=0 next cycle, hi/lo keep prior values, done never pulses; reset asserted mid-MUL → hi=lo=0, busy=0 immediately.
- Back-to-back MULTU then DIVU held under stall → second op accepted in the first op's done cycle; results correct for both.
